// File: rtl/boot_pkg.sv
// Shared boot-frame constants and loader state encoding, also used by the host-side bench model.
package boot_pkg;

  localparam logic [7:0] SYNC_BYTE_1 = 8'hA5;
  localparam logic [7:0] SYNC_BYTE_2 = 8'h5A;

  localparam int STATE_W = 4;

  localparam logic [3:0] ST_SYNC1   = 4'd0;
  localparam logic [3:0] ST_SYNC2   = 4'd1;
  localparam logic [3:0] ST_LEN_HI  = 4'd2;
  localparam logic [3:0] ST_LEN_LO  = 4'd3;
  localparam logic [3:0] ST_DATA_LO = 4'd4;
  localparam logic [3:0] ST_DATA_HI = 4'd5;
  localparam logic [3:0] ST_WRITE   = 4'd6;
  localparam logic [3:0] ST_CHECK   = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;
  localparam logic [3:0] ST_ERROR   = 4'd9;

  // States in which the loader is willing to take a byte from the receiver.
  function automatic logic accepts_bytes(input logic [3:0] st);
    return st inside {ST_SYNC1, ST_SYNC2, ST_LEN_HI, ST_LEN_LO,
                      ST_DATA_LO, ST_DATA_HI, ST_CHECK};
  endfunction

endpackage

// File: rtl/boot_loader_if.sv
// Bundle of the byte-stream handshake, boot-memory write port and status lines of boot_loader.
interface boot_loader_if #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 16
);
  // rx_data is transferred on a rising clock edge where rx_valid && rx_ready; the
  // sender holds rx_data stable while rx_valid is high and the byte is not yet taken.
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    rx_ready;
  logic [ADDRESS_BITS-1:0] mem_address;
  logic [BITS-1:0]         mem_data;
  logic                    mem_wr;
  logic                    boot_done;
  logic                    boot_error;
  logic                    cpu_reset;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_address, mem_data, mem_wr, boot_done, boot_error, cpu_reset
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_address, mem_data, mem_wr, boot_done, boot_error, cpu_reset
  );
endinterface

// File: rtl/boot_loader.sv
// Receives a sync/length/data/checksum byte frame and writes its 16-bit words into boot memory,
// releasing the CPU only when the checksum matches.
module boot_loader
  import boot_pkg::*;
#(
  parameter int          BITS          = 16,
  parameter int          ADDRESS_BITS  = 16,
  parameter int unsigned START_ADDRESS = 0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [7:0]              RX_DATA,
  input  logic                    RX_VALID,
  output logic                    RX_READY,
  output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
  output logic [BITS-1:0]         MEM_DATA,
  output logic                    MEM_WR,
  output logic                    BOOT_DONE,
  output logic                    BOOT_ERROR,
  output logic                    CPU_RESET
);

  localparam logic [ADDRESS_BITS-1:0] START_ADDR = ADDRESS_BITS'(START_ADDRESS);

  logic [STATE_W-1:0]      state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [15:0]             count_q, count_d;
  logic [7:0]              sum_q, sum_d;
  logic [7:0]              lo_q, lo_d;
  logic [7:0]              len_hi_q, len_hi_d;
  logic [BITS-1:0]         data_q, data_d;
  logic [15:0]             word_in;
  logic [BITS-1:0]         word_fit;
  logic                    accept;

  assign RX_READY = !RST && accepts_bytes(state_q);
  assign accept   = RX_VALID && RX_READY;
  assign word_in  = {RX_DATA, lo_q};

  // Fit the assembled 16-bit word onto the memory data width.
  generate
    if (BITS > 16) begin : g_word_ext
      assign word_fit = {{(BITS-16){1'b0}}, word_in};
    end else if (BITS == 16) begin : g_word_eq
      assign word_fit = word_in;
    end else begin : g_word_trunc
      assign word_fit = word_in[BITS-1:0];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    count_d  = count_q;
    sum_d    = sum_q;
    lo_d     = lo_q;
    len_hi_d = len_hi_q;
    data_d   = data_q;
    case (state_q)
      ST_SYNC1: begin
        if (accept && RX_DATA == SYNC_BYTE_1) state_d = ST_SYNC2;
      end
      ST_SYNC2: begin
        if (accept) begin
          if (RX_DATA == SYNC_BYTE_2) begin
            // A fresh frame always starts from a clean sum and the base address.
            state_d = ST_LEN_HI;
            sum_d   = 8'h00;
            addr_d  = START_ADDR;
          end else if (RX_DATA != SYNC_BYTE_1) begin
            state_d = ST_SYNC1;
          end
        end
      end
      ST_LEN_HI: begin
        if (accept) begin
          len_hi_d = RX_DATA;
          state_d  = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (accept) begin
          count_d = {len_hi_q, RX_DATA};
          state_d = ({len_hi_q, RX_DATA} == 16'd0) ? ST_CHECK : ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (accept) begin
          lo_d    = RX_DATA;
          sum_d   = sum_q + RX_DATA;
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (accept) begin
          data_d  = word_fit;
          sum_d   = sum_q + RX_DATA;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        addr_d  = addr_q + ADDRESS_BITS'(1);
        count_d = count_q - 16'd1;
        state_d = (count_q == 16'd1) ? ST_CHECK : ST_DATA_LO;
      end
      ST_CHECK: begin
        if (accept) state_d = (RX_DATA == sum_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        state_d = state_q;
      end
      default: begin
        state_d = ST_SYNC1;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_SYNC1;
      addr_q   <= START_ADDR;
      count_q  <= 16'd0;
      sum_q    <= 8'h00;
      lo_q     <= 8'h00;
      len_hi_q <= 8'h00;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      count_q  <= count_d;
      sum_q    <= sum_d;
      lo_q     <= lo_d;
      len_hi_q <= len_hi_d;
      data_q   <= data_d;
    end
  end

  // Reset in the WRITE cycle kills the strobe immediately so the aborted word never lands.
  assign MEM_WR      = (state_q == ST_WRITE) && !RST;
  assign MEM_ADDRESS = addr_q;
  assign MEM_DATA    = data_q;
  assign BOOT_DONE   = (state_q == ST_DONE);
  assign BOOT_ERROR  = (state_q == ST_ERROR);
  assign CPU_RESET   = (state_q != ST_DONE);

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: a cycle-by-cycle vector table plus handshake-gap and address-wrap sequences.
module tb_boot_loader;
  import boot_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_w;
  logic [7:0] rx_data;
  logic       rx_valid;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  boot_loader_if #(.BITS(16), .ADDRESS_BITS(16)) bif ();
  boot_loader_if #(.BITS(16), .ADDRESS_BITS(16)) bif_w ();

  assign bif.rx_data    = rx_data;
  assign bif.rx_valid   = rx_valid;
  assign bif_w.rx_data  = rx_data;
  assign bif_w.rx_valid = rx_valid;

  boot_loader #(.BITS(16), .ADDRESS_BITS(16), .START_ADDRESS(0)) u_dut (
    .CLK(clk), .RST(rst),
    .RX_DATA(bif.rx_data), .RX_VALID(bif.rx_valid), .RX_READY(bif.rx_ready),
    .MEM_ADDRESS(bif.mem_address), .MEM_DATA(bif.mem_data), .MEM_WR(bif.mem_wr),
    .BOOT_DONE(bif.boot_done), .BOOT_ERROR(bif.boot_error), .CPU_RESET(bif.cpu_reset)
  );

  boot_loader #(.BITS(16), .ADDRESS_BITS(16), .START_ADDRESS(16'hFFFF)) u_dut_w (
    .CLK(clk), .RST(rst_w),
    .RX_DATA(bif_w.rx_data), .RX_VALID(bif_w.rx_valid), .RX_READY(bif_w.rx_ready),
    .MEM_ADDRESS(bif_w.mem_address), .MEM_DATA(bif_w.mem_data), .MEM_WR(bif_w.mem_wr),
    .BOOT_DONE(bif_w.boot_done), .BOOT_ERROR(bif_w.boot_error), .CPU_RESET(bif_w.cpu_reset)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected {address, data} of every write, in order.
  logic [31:0] exp_q[$];
  logic [31:0] got_w[$];
  logic [15:0] mem_model [logic [15:0]];

  always @(negedge clk) begin
    if (bif.mem_wr === 1'b1) begin
      chk("ready_low_during_wr", {31'd0, bif.rx_ready}, 32'd0);
      mem_model[bif.mem_address] = bif.mem_data;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_wr actual=0x%0h_%0h expected=no_write", bif.mem_address, bif.mem_data);
      end else begin
        chk("wr_addr_data", {bif.mem_address, bif.mem_data}, exp_q.pop_front());
      end
    end
    if (bif_w.mem_wr === 1'b1) got_w.push_back({bif_w.mem_address, bif_w.mem_data});
  end

  typedef struct {
    logic        rst;
    logic        valid;
    logic [7:0]  data;
    logic        e_ready;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [15:0] e_data;
    logic        e_done;
    logic        e_err;
    logic        e_cpu;
  } vec_t;

  vec_t vecs[$];

  task automatic add_v(input logic r, input logic v, input logic [7:0] d, input logic rdy,
                       input logic wr, input logic [15:0] a, input logic [15:0] md,
                       input logic dn, input logic er, input logic cpu);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.e_ready = rdy; x.e_wr = wr;
    x.e_addr = a; x.e_data = md; x.e_done = dn; x.e_err = er; x.e_cpu = cpu;
    vecs.push_back(x);
  endtask

  // Byte accepted in a ready, non-terminal state with no write in progress.
  task automatic add_b(input logic [7:0] d);
    add_v(1'b0, 1'b1, d, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic send_byte(input int which, input logic [7:0] b);
    int   gaps;
    logic acc;
    gaps = $urandom_range(0, 3);
    repeat (gaps) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    acc      = 1'b0;
    for (int n = 0; n < 40 && !acc; n++) begin
      @(negedge clk);
      acc = (which != 0) ? bif_w.rx_ready : bif.rx_ready;
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    chk("byte_handshake", {31'd0, acc}, 32'd1);
  endtask

  task automatic wait_done(input int which);
    logic dn;
    dn = 1'b0;
    for (int n = 0; n < 30 && !dn; n++) begin
      @(negedge clk);
      dn = (which != 0) ? bif_w.boot_done : bif.boot_done;
    end
    chk("boot_done_reached", {31'd0, dn}, 32'd1);
  endtask

  logic [7:0] frame_a [9];
  logic [7:0] frame_w [9];

  initial begin
    rst      = 1'b1;
    rst_w    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    // Good two-word frame, valid held high; DONE is terminal.
    add_v(1, 0, 8'h00, 0, 0, 16'h0, 16'h0, 0, 0, 1);
    add_b(8'hA5); add_b(8'h5A); add_b(8'h00); add_b(8'h02); add_b(8'h34); add_b(8'h12);
    add_v(0, 1, 8'h78, 0, 1, 16'h0000, 16'h1234, 0, 0, 1);
    add_b(8'h78); add_b(8'h56);
    add_v(0, 1, 8'h14, 0, 1, 16'h0001, 16'h5678, 0, 0, 1);
    add_b(8'h14);
    add_v(0, 1, 8'hA5, 0, 0, 16'h0, 16'h0, 1, 0, 0);
    add_v(0, 1, 8'hA5, 0, 0, 16'h0, 16'h0, 1, 0, 0);
    // Same frame with a bad checksum.
    add_v(1, 0, 8'h00, 0, 0, 16'h0, 16'h0, 1, 0, 0);
    add_v(1, 0, 8'h00, 0, 0, 16'h0, 16'h0, 0, 0, 1);
    add_b(8'hA5); add_b(8'h5A); add_b(8'h00); add_b(8'h02); add_b(8'h34); add_b(8'h12);
    add_v(0, 1, 8'h78, 0, 1, 16'h0000, 16'h1234, 0, 0, 1);
    add_b(8'h78); add_b(8'h56);
    add_v(0, 1, 8'h15, 0, 1, 16'h0001, 16'h5678, 0, 0, 1);
    add_b(8'h15);
    add_v(0, 1, 8'hA5, 0, 0, 16'h0, 16'h0, 0, 1, 1);
    add_v(0, 1, 8'h14, 0, 0, 16'h0, 16'h0, 0, 1, 1);
    // Garbage and repeated sync, then a zero-length frame.
    add_v(1, 0, 8'h00, 0, 0, 16'h0, 16'h0, 0, 1, 1);
    add_v(1, 0, 8'h00, 0, 0, 16'h0, 16'h0, 0, 0, 1);
    add_b(8'h00); add_b(8'hA5); add_b(8'hA5); add_b(8'h5A); add_b(8'h00); add_b(8'h00); add_b(8'h00);
    add_v(0, 0, 8'h00, 0, 0, 16'h0, 16'h0, 1, 0, 0);
    // Reset after the first data byte, reset during WRITE, then a clean frame with a stall.
    add_v(1, 0, 8'h00, 0, 0, 16'h0, 16'h0, 1, 0, 0);
    add_v(1, 0, 8'h00, 0, 0, 16'h0, 16'h0, 0, 0, 1);
    add_b(8'hA5); add_b(8'h5A); add_b(8'h00); add_b(8'h02); add_b(8'h34);
    add_v(1, 0, 8'h00, 0, 0, 16'h0, 16'h0, 0, 0, 1);
    add_b(8'hA5); add_b(8'h5A); add_b(8'h00); add_b(8'h01); add_b(8'hAB); add_b(8'hCD);
    add_v(1, 0, 8'h00, 0, 0, 16'h0, 16'h0, 0, 0, 1);
    add_b(8'hA5); add_b(8'h5A); add_b(8'h00); add_b(8'h02);
    add_v(0, 0, 8'h11, 1, 0, 16'h0, 16'h0, 0, 0, 1);
    add_b(8'h11); add_b(8'h11);
    add_v(0, 1, 8'h22, 0, 1, 16'h0000, 16'h1111, 0, 0, 1);
    add_b(8'h22); add_b(8'h22);
    add_v(0, 1, 8'h66, 0, 1, 16'h0001, 16'h2222, 0, 0, 1);
    add_b(8'h66);
    add_v(0, 0, 8'h00, 0, 0, 16'h0, 16'h0, 1, 0, 0);

    exp_q.push_back({16'h0000, 16'h1234}); exp_q.push_back({16'h0001, 16'h5678});
    exp_q.push_back({16'h0000, 16'h1234}); exp_q.push_back({16'h0001, 16'h5678});
    exp_q.push_back({16'h0000, 16'h1111}); exp_q.push_back({16'h0001, 16'h2222});

    for (int i = 0; i < vecs.size(); i++) begin
      rst      = vecs[i].rst;
      rx_valid = vecs[i].valid;
      rx_data  = vecs[i].data;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), {31'd0, bif.rx_ready}, {31'd0, vecs[i].e_ready});
      chk($sformatf("v%0d_wr", i), {31'd0, bif.mem_wr}, {31'd0, vecs[i].e_wr});
      if (vecs[i].e_wr) begin
        chk($sformatf("v%0d_addr", i), {16'd0, bif.mem_address}, {16'd0, vecs[i].e_addr});
        chk($sformatf("v%0d_data", i), {16'd0, bif.mem_data}, {16'd0, vecs[i].e_data});
      end
      chk($sformatf("v%0d_done", i), {31'd0, bif.boot_done}, {31'd0, vecs[i].e_done});
      chk($sformatf("v%0d_error", i), {31'd0, bif.boot_error}, {31'd0, vecs[i].e_err});
      chk($sformatf("v%0d_cpu_reset", i), {31'd0, bif.cpu_reset}, {31'd0, vecs[i].e_cpu});
      @(posedge clk); #1;
    end
    chk("table_writes_drained", exp_q.size(), 32'd0);
    chk("table_mem0", {16'd0, mem_model[16'h0000]}, 32'h1111);
    chk("table_mem1", {16'd0, mem_model[16'h0001]}, 32'h2222);

    // Good frame with random valid gaps must rebuild the same image.
    frame_a = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
    rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back({16'h0000, 16'h1234});
    exp_q.push_back({16'h0001, 16'h5678});
    for (int i = 0; i < 9; i++) send_byte(0, frame_a[i]);
    wait_done(0);
    chk("gaps_writes_drained", exp_q.size(), 32'd0);
    chk("gaps_mem0", {16'd0, mem_model[16'h0000]}, 32'h1234);
    chk("gaps_mem1", {16'd0, mem_model[16'h0001]}, 32'h5678);
    chk("gaps_cpu_reset", {31'd0, bif.cpu_reset}, 32'd0);
    chk("gaps_error", {31'd0, bif.boot_error}, 32'd0);

    // Address wrap from the top of memory on the second instance.
    frame_w = '{8'hA5, 8'h5A, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
    rst = 1'b1;
    @(posedge clk); #1;
    rst_w = 1'b0;
    for (int i = 0; i < 9; i++) send_byte(1, frame_w[i]);
    wait_done(1);
    chk("wrap_write_count", got_w.size(), 32'd2);
    if (got_w.size() >= 2) begin
      chk("wrap_first_write", got_w[0], {16'hFFFF, 16'h0001});
      chk("wrap_second_write", got_w[1], {16'h0000, 16'h0002});
    end
    chk("wrap_cpu_reset", {31'd0, bif_w.cpu_reset}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
